// File: rtl/dram_zero_fill.sv
// AXI4 write initiator that fills a DRAM window with a constant pattern after
// calibration, issuing fixed-length INCR bursts with one burst outstanding.
module dram_zero_fill #(
  parameter int unsigned             AxiAddrWidth = 64,
  parameter int unsigned             AxiDataWidth = 64,
  parameter int unsigned             AxiIdWidth   = 5,
  parameter logic [AxiAddrWidth-1:0] BaseAddr     = AxiAddrWidth'(64'h8000_0000),
  parameter longint unsigned         NumBytes     = 24*1024*1024,
  parameter int unsigned             BurstLen     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      calib_done_i,
  input  logic [AxiDataWidth-1:0]   pattern_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [AxiIdWidth-1:0]     aw_id,
  output logic [AxiAddrWidth-1:0]   aw_addr,
  output logic [7:0]                aw_len,
  output logic [2:0]                aw_size,
  output logic [1:0]                aw_burst,
  output logic                      aw_valid,
  input  logic                      aw_ready,
  output logic [AxiDataWidth-1:0]   w_data,
  output logic [AxiDataWidth/8-1:0] w_strb,
  output logic                      w_last,
  output logic                      w_valid,
  input  logic                      w_ready,
  input  logic [AxiIdWidth-1:0]     b_id,
  input  logic [1:0]                b_resp,
  input  logic                      b_valid,
  output logic                      b_ready
);
  localparam int unsigned     BeatBytes  = AxiDataWidth / 8;
  localparam int unsigned     BurstBytes = BurstLen * BeatBytes;
  localparam longint unsigned NumBursts  = NumBytes / BurstBytes;
  localparam int unsigned     BurstCntW  = $clog2(NumBursts + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [AxiAddrWidth-1:0] r_addr;
  logic [BurstCntW-1:0]    r_burst_cnt;
  logic [7:0]              r_beat;
  logic [AxiDataWidth-1:0] r_pattern;
  logic                    r_done;
  logic                    r_error;

  logic w_start;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_last_beat;
  logic w_last_burst;
  logic w_unused_bid;

  assign w_start      = (r_state == ST_IDLE) && start_i && calib_done_i;
  assign w_aw_hs      = (r_state == ST_ADDR) && aw_ready;
  assign w_w_hs       = (r_state == ST_DATA) && w_ready;
  assign w_b_hs       = (r_state == ST_RESP) && b_valid;
  assign w_last_beat  = (r_beat == 8'(BurstLen - 1));
  assign w_last_burst = (r_burst_cnt == BurstCntW'(1));
  // Only ID 0 is ever issued, so the returned ID carries no information.
  assign w_unused_bid = ^b_id;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_ADDR;
      ST_ADDR: if (aw_ready) w_state_nxt = ST_DATA;
      ST_DATA: if (w_ready && w_last_beat) w_state_nxt = ST_RESP;
      ST_RESP: if (b_valid) w_state_nxt = w_last_burst ? ST_DONE : ST_ADDR;
      ST_DONE: if (!start_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr      <= BaseAddr;
      r_burst_cnt <= '0;
      r_beat      <= '0;
      r_pattern   <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr      <= BaseAddr;
        r_burst_cnt <= BurstCntW'(NumBursts);
        r_pattern   <= pattern_i;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
      end
      if (w_aw_hs) r_beat <= '0;
      if (w_w_hs)  r_beat <= r_beat + 8'd1;
      // A bad response is recorded but the fill carries on to the end.
      if (w_b_hs) begin
        if (b_resp != 2'b00) r_error <= 1'b1;
        r_addr      <= r_addr + AxiAddrWidth'(BurstBytes);
        r_burst_cnt <= r_burst_cnt - BurstCntW'(1);
        if (w_last_burst) r_done <= 1'b1;
      end
    end
  end

  assign aw_id    = '0;
  assign aw_addr  = r_addr;
  assign aw_len   = 8'(BurstLen - 1);
  assign aw_size  = 3'($clog2(BeatBytes));
  assign aw_burst = 2'b01;
  assign aw_valid = (r_state == ST_ADDR);
  assign w_data   = r_pattern;
  assign w_strb   = '1;
  assign w_last   = (r_state == ST_DATA) && w_last_beat;
  assign w_valid  = (r_state == ST_DATA);
  assign b_ready  = (r_state == ST_RESP);
  assign busy_o   = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_RESP);
  assign done_o   = r_done;
  assign error_o  = r_error;

endmodule
